matrix_multiply_gen: RTL
========================

Name: matrix_multiply_gen

Overview:
Parametrised successor to the fixed M x K by K x 1 multiplier in the AXI Stream coprocessor. Computes RES = A x B for a general M x K by K x N unsigned matrix product, all matrices row-major. Reads A_RAM and B_RAM synchronously through a pipelined multiply-accumulate datapath. Writes scaled, optionally saturated results to RES_RAM. Sits between myip_v1_0 and the three RAMs.

Parameters:
width, 8, bits per RAM element (A, B and RES)
M_rows, 2, rows of A and of RES
K_cols, 4, columns of A, which is also the rows of B
N_cols, 1, columns of B and of RES
A_depth_bits, 3, A_RAM address bits; 2^A_depth_bits >= M_rows*K_cols
B_depth_bits, 2, B_RAM address bits; 2^B_depth_bits >= K_cols*N_cols
RES_depth_bits, 1, RES_RAM address bits; 2^RES_depth_bits >= M_rows*N_cols
ACC_width, 2*width+$clog2(K_cols)+1, accumulator width; cannot overflow

Ports:
clk  in  1  clock, all logic on the rising edge
resetn  in  1  synchronous reset, active low
Start  in  1  starts a computation; sampled only in IDLE
shift  in  $clog2(ACC_width)  right-shift applied to the accumulator; latched at Start
sat_en  in  1  1 = clamp the output to 2^width-1; 0 = truncate; latched at Start
Done  out  1  one-cycle pulse when the computation completes
busy  out  1  high from the cycle after Start is accepted until Done, inclusive
A_read_en  out  1  A_RAM read enable
A_read_address  out  A_depth_bits  A_RAM address; element A[r][k] is at r*K_cols+k
A_read_data_out  in  width  A_RAM data, valid one cycle after the address
B_read_en  out  1  B_RAM read enable
B_read_address  out  B_depth_bits  B_RAM address; element B[k][n] is at k*N_cols+n
B_read_data_out  in  width  B_RAM data, valid one cycle after the address
RES_write_en  out  1  RES_RAM write strobe
RES_write_address  out  RES_depth_bits  RES_RAM address; element RES[r][n] is at r*N_cols+n
RES_write_data_in  out  width  RES_RAM write data

Behaviour:
- Reset (resetn=0 at a clock edge):
  - FSM goes to IDLE; counters r, n, k, the pipeline valid bits, the accumulator and the latched shift/sat_en are cleared.
  - All outputs are 0.
  - Applies equally in the middle of an operation; no RES write occurs after the reset edge.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, FINISH.
- IDLE:
  - Start=1 latches shift and sat_en, clears r, n, k and the accumulator, then goes to ISSUE.
  - Start is ignored in every other state.
- ISSUE:
  - Lasts K_cols cycles; each cycle drives A_read_en=B_read_en=1 and the addresses for the current r, n, k, then k increments.
  - When k reaches K_cols-1, go to DRAIN.
- Datapath pipeline:
  - Stage 1: RAM data returns.
  - Stage 2: product register, 2*width bits.
  - Stage 3: accumulator += product, gated by a valid bit delayed 2 cycles from each issue cycle.
- DRAIN: lasts 2 cycles with read enables low. Afterwards the accumulator holds the complete sum for RES[r][n]. Go to WRITE.
- WRITE (1 cycle):
  - Drive RES_write_en=1 and RES_write_address=r*N_cols+n.
  - Compute s = acc >> shift. RES_write_data_in = (sat_en && s > 2^width-1) ? all ones : s[width-1:0].
  - Clear the accumulator and k.
  - Advance n; when n wraps from N_cols-1 to 0, advance r.
  - If r==M_rows-1 and n==N_cols-1, go to FINISH; otherwise go to ISSUE.
- FINISH: Done=1 for one cycle, then IDLE. busy falls in the following cycle.
- Latency:
  - Start is sampled at cycle 0, ISSUE begins at cycle 1.
  - Each result element takes K_cols+3 cycles.
  - Done is asserted at cycle 1 + M_rows*N_cols*(K_cols+3).
- Outputs are registered or decoded from the state only. Read enables, addresses and the write fields are 0 in any state where they are unused.
- Arithmetic is unsigned throughout. Default shift=8 and sat_en=0 reproduce the previous block (accumulator bits [15:8]).
- Elaboration check: any depth parameter too small for its matrix must fail elaboration, via $error in a generate block.

Decomposition:
- Package matmul_pkg:
  - FSM state encoding (one-hot, 5 states).
  - Functions for the default ACC_width and for the row-major address calculation.
- One sub-module, mac_pipe: product register, valid delay line, accumulator with synchronous clear, and shift/saturate output logic.
- The FSM, counters and address generation live in the top module.

Test Plan:
- Defaults (M=2, K=4, N=1), shift=8, sat_en=0; A all 0x10, B all 0x10 -> RES[0]=RES[1]=0x04 (sum 0x400). Done at cycle 15 after Start; exactly 2 writes.
- M=2, K=2, N=2, shift=0, A=[[1,0],[0,1]], B=[[3,5],[7,9]] -> RES=[3,5,7,9] written at addresses 0,1,2,3 in order.
- Defaults, A all 0xFF, B all 0xFF, shift=8 (sum 0x3F804) -> sat_en=1 gives 0xFF per row; sat_en=0 gives 0xF8 per row.
- Start held high through a whole run, and pulsed mid-run -> single run only; Done exactly once; no extra writes; busy low for 1 cycle after Done before a new run starts.
- resetn=0 during the second ISSUE phase -> next cycle all outputs 0 and state IDLE; no RES write; a fresh Start then produces correct results.
- Addresses checked against the reference model every issue cycle; read enables low in DRAIN/WRITE/IDLE.

Source files
------------

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and sizing/address helpers for matrix_multiply_gen
package matmul_pkg;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_ISSUE  = 5'b00010,
    S_DRAIN  = 5'b00100,
    S_WRITE  = 5'b01000,
    S_FINISH = 5'b10000
  } state_t;

  // Wide enough that K_cols full-scale products can never overflow.
  function automatic int acc_width_default(input int width, input int k_cols);
    return 2 * width + $clog2(k_cols) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rm_addr(input int unsigned row, input int unsigned col,
                                          input int unsigned ncols);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - product register, issue-valid delay line, accumulator and shift/saturate output
module mac_pipe #(
  parameter int width     = 8,
  parameter int ACC_width = 19
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         issue_valid,
  input  logic [width-1:0]             a_data,
  input  logic [width-1:0]             b_data,
  input  logic                         acc_clear,
  input  logic [$clog2(ACC_width)-1:0] shift,
  input  logic                         sat_en,
  output logic [width-1:0]             res_data
);

  localparam logic [ACC_width-1:0] RES_MAX = ACC_width'({width{1'b1}});

  logic                   data_valid;
  logic                   prod_valid;
  logic [2*width-1:0]     prod;
  logic [ACC_width-1:0]   acc;
  logic [ACC_width-1:0]   scaled;

  // data_valid lines up with RAM data, prod_valid with the product register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_valid <= 1'b0;
      prod_valid <= 1'b0;
      prod       <= '0;
      acc        <= '0;
    end else begin
      data_valid <= issue_valid;
      prod_valid <= data_valid;
      if (data_valid) begin
        prod <= (2*width)'(a_data) * (2*width)'(b_data);
      end
      if (acc_clear) begin
        acc <= '0;
      end else if (prod_valid) begin
        acc <= acc + ACC_width'(prod);
      end
    end
  end

  always_comb begin
    scaled   = acc >> shift;
    res_data = (sat_en && (scaled > RES_MAX)) ? '1 : scaled[width-1:0];
  end

endmodule

// File: rtl/matrix_multiply_gen.sv
// rtl/matrix_multiply_gen.sv - M x K by K x N unsigned matrix multiplier between RAM ports
module matrix_multiply_gen
  import matmul_pkg::*;
#(
  parameter int width          = 8,
  parameter int M_rows         = 2,
  parameter int K_cols         = 4,
  parameter int N_cols         = 1,
  parameter int A_depth_bits   = 3,
  parameter int B_depth_bits   = 2,
  parameter int RES_depth_bits = 1,
  parameter int ACC_width      = acc_width_default(width, K_cols)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         Start,
  input  logic [$clog2(ACC_width)-1:0] shift,
  input  logic                         sat_en,
  output logic                         Done,
  output logic                         busy,
  output logic                         A_read_en,
  output logic [A_depth_bits-1:0]      A_read_address,
  input  logic [width-1:0]             A_read_data_out,
  output logic                         B_read_en,
  output logic [B_depth_bits-1:0]      B_read_address,
  input  logic [width-1:0]             B_read_data_out,
  output logic                         RES_write_en,
  output logic [RES_depth_bits-1:0]    RES_write_address,
  output logic [width-1:0]             RES_write_data_in
);

  localparam int R_W  = cnt_width(M_rows);
  localparam int N_W  = cnt_width(N_cols);
  localparam int K_W  = cnt_width(K_cols);
  localparam int SH_W = $clog2(ACC_width);

  generate
    if ((2 ** A_depth_bits) < M_rows * K_cols) begin : g_a_depth_err
      $error("A_depth_bits too small for M_rows*K_cols");
    end
    if ((2 ** B_depth_bits) < K_cols * N_cols) begin : g_b_depth_err
      $error("B_depth_bits too small for K_cols*N_cols");
    end
    if ((2 ** RES_depth_bits) < M_rows * N_cols) begin : g_res_depth_err
      $error("RES_depth_bits too small for M_rows*N_cols");
    end
  endgenerate

  state_t            state, state_n;
  logic [R_W-1:0]    r;
  logic [N_W-1:0]    n;
  logic [K_W-1:0]    k;
  logic              drain_cnt;
  logic [SH_W-1:0]   shift_q;
  logic              sat_q;
  logic              acc_clear;
  logic [width-1:0]  res_data;
  logic              k_last, n_last, last_elem;

  assign k_last    = (k == K_W'(K_cols - 1));
  assign n_last    = (n == N_W'(N_cols - 1));
  assign last_elem = n_last && (r == R_W'(M_rows - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (Start) state_n = S_ISSUE;
      S_ISSUE:  if (k_last) state_n = S_DRAIN;
      S_DRAIN:  if (drain_cnt) state_n = S_WRITE;
      S_WRITE:  state_n = last_elem ? S_FINISH : S_ISSUE;
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Counters walk RES row-major; k holds at K_cols-1 until WRITE clears it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r         <= '0;
      n         <= '0;
      k         <= '0;
      drain_cnt <= 1'b0;
      shift_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            shift_q   <= shift;
            sat_q     <= sat_en;
            r         <= '0;
            n         <= '0;
            k         <= '0;
            drain_cnt <= 1'b0;
          end
        end
        S_ISSUE: if (!k_last) k <= k + 1'b1;
        S_DRAIN: drain_cnt <= ~drain_cnt;
        S_WRITE: begin
          k <= '0;
          if (n_last) begin
            n <= '0;
            r <= (r == R_W'(M_rows - 1)) ? '0 : r + 1'b1;
          end else begin
            n <= n + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Done              = (state == S_FINISH);
    busy              = (state != S_IDLE);
    A_read_en         = 1'b0;
    B_read_en         = 1'b0;
    A_read_address    = '0;
    B_read_address    = '0;
    RES_write_en      = 1'b0;
    RES_write_address = '0;
    RES_write_data_in = '0;
    acc_clear         = 1'b0;
    case (state)
      S_IDLE: acc_clear = Start;
      S_ISSUE: begin
        A_read_en      = 1'b1;
        B_read_en      = 1'b1;
        A_read_address = A_depth_bits'(rm_addr(32'(r), 32'(k), K_cols));
        B_read_address = B_depth_bits'(rm_addr(32'(k), 32'(n), N_cols));
      end
      S_WRITE: begin
        RES_write_en      = 1'b1;
        RES_write_address = RES_depth_bits'(rm_addr(32'(r), 32'(n), N_cols));
        RES_write_data_in = res_data;
        acc_clear         = 1'b1;
      end
      default: ;
    endcase
  end

  mac_pipe #(
    .width     (width),
    .ACC_width (ACC_width)
  ) u_mac_pipe (
    .clk         (clk),
    .resetn      (resetn),
    .issue_valid (A_read_en),
    .a_data      (A_read_data_out),
    .b_data      (B_read_data_out),
    .acc_clear   (acc_clear),
    .shift       (shift_q),
    .sat_en      (sat_q),
    .res_data    (res_data)
  );

endmodule
